// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit: byte/half/word load-store engine for a big-endian,
// word-wide data memory; sub-word stores are done as read-modify-write.
module load_store_unit #(
    parameter int READ_WAIT = 2,
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_writeenable,
    output logic        mem_read,
    input  logic [31:0] mem_data
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 4);
    localparam logic [3:0]  WAIT_INIT = 4'(READ_WAIT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        req_err, accept, capture;
    logic [4:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val, merged;

    // Legality of the incoming request: bad size, misaligned, or past last word.
    always_comb begin
        req_err = (req_size == 2'b11)
               || (req_size == 2'b01 && req_addr[0])
               || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
               || (req_addr > LAST_ADDR);
    end

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic plus all handshake and memory strobes.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        accept          = 1'b0;
        capture         = 1'b0;
        req_ready       = 1'b0;
        mem_read        = 1'b0;
        mem_writeenable = 1'b0;
        mem_address     = 32'h0;
        mem_writedata   = 32'h0;
        resp_valid      = 1'b0;
        resp_err        = 1'b0;
        resp_rdata      = 32'h0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_write && req_size == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            RD_WAIT: begin
                mem_read    = 1'b1;
                mem_address = {addr_q[31:2], 2'b00};
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = write_q ? WRITE : RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                mem_writeenable = 1'b1;
                mem_address     = {addr_q[31:2], 2'b00};
                mem_writedata   = wdata_q;
                state_d         = RESP;
            end
            RESP: begin
                resp_valid  = 1'b1;
                resp_err    = err_q;
                resp_rdata  = rdata_q;
                mem_address = {addr_q[31:2], 2'b00};
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Big-endian lane select for loads and lane merge for sub-word stores.
    always_comb begin
        lane    = {~addr_q[1:0], 3'b000};
        ld_byte = mem_data[lane +: 8];
        ld_half = addr_q[1] ? mem_data[15:0] : mem_data[31:16];
        ld_val  = mem_data;
        merged  = mem_data;
        unique case (size_q)
            2'b00: begin
                ld_val = {{24{~uns_q & ld_byte[7]}}, ld_byte};
                merged[lane +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                ld_val = {{16{~uns_q & ld_half[15]}}, ld_half};
                if (addr_q[1]) merged[15:0] = wdata_q[15:0];
                else           merged[31:16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // Request capture on acceptance; load result or merged store word on read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            err_q   <= req_err;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
        end else if (capture) begin
            if (write_q) wdata_q <= merged;
            else         rdata_q <= ld_val;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// tb_load_store_unit: randomized and directed checks of load_store_unit
// against a byte-array memory model.
module tb_load_store_unit;
    localparam int RW = 2;
    localparam int MB = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_writeenable, mem_read;
    logic [31:0] resp_rdata, mem_address, mem_writedata, mem_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.READ_WAIT(RW), .MEM_BYTES(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_writeenable(mem_writeenable), .mem_read(mem_read),
        .mem_data(mem_data)
    );

    logic [31:0] mem_w [0:255];
    logic [7:0]  refb [0:MB-1];
    int init_i = 0;

    function automatic logic [31:0] init_val(int i);
        return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0000;
    endfunction

    always @(posedge clk) begin
        if (init_i < 256) begin
            mem_w[init_i[7:0]] <= init_val(init_i);
            init_i <= init_i + 1;
        end else if (mem_writeenable) begin
            mem_w[mem_address[9:2]] <= mem_writedata;
        end
    end
    assign mem_data = mem_w[mem_address[9:2]];

    function automatic logic [31:0] ref_word(int wi);
        return {refb[4*wi], refb[4*wi+1], refb[4*wi+2], refb[4*wi+3]};
    endfunction

    // Reference: memory as a byte array, byte a+0 most significant.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic e,
                         output int lat, output int nrd, output int nwe);
        int n;
        logic [31:0] v;
        e = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
            (sz == 2'd2 && a[1:0] != 2'd0) || (a > 32'(MB - 4));
        rd = '0; nrd = 0; nwe = 0; lat = 1;
        if (e) return;
        n = 1 << sz;
        if (w) begin
            for (int i = 0; i < n; i++) refb[int'(a) + i] = wd[8*(n-1-i) +: 8];
            nwe = 1;
            nrd = (n == 4) ? 0 : RW;
            lat = (n == 4) ? 2 : RW + 2;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(refb[int'(a) + i]);
            if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v; nrd = RW; lat = RW + 1;
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output logic e, output int lat,
                           output int nrd, output int nwe, output int nboth,
                           output int nadr);
        rd = '0; e = 1'b0; lat = -1; nrd = 0; nwe = 0; nboth = 0; nadr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_writeenable) nwe++;
            if (mem_read && mem_writeenable) nboth++;
            if (mem_address !== {a[31:2], 2'b00}) nadr++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; e = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({req_ready, resp_valid, resp_err, mem_read, mem_writeenable} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctl got %b want 10000",
                     {req_ready, resp_valid, resp_err, mem_read, mem_writeenable});
        end
        total++;
        if ({mem_address, mem_writedata, resp_rdata} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data got %h want 0", {mem_address, mem_writedata, resp_rdata});
        end
        repeat (262) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] rd, erd; logic e, ee;
        int lat, nrd, nwe, nb, na, elat, enrd, enwe;
        model(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, erd, ee, elat, enrd, enwe);
        run_req(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (lat !== 2 || nwe !== 1 || nrd !== 0 || e !== 1'b0) begin
            bad++;
            $display("FAIL word_store lat/we/rd/err got %0d/%0d/%0d/%b want 2/1/0/0", lat, nwe, nrd, e);
        end
        total++;
        if (mem_w[4] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL word_store_mem got %h want deadbeef", mem_w[4]);
        end
        model(0, 2'd2, 0, 32'h10, 0, erd, ee, elat, enrd, enwe);
        run_req(0, 2'd2, 0, 32'h10, 0, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0 || lat !== RW + 1) begin
            bad++;
            $display("FAIL word_load rdata/err/lat got %h/%b/%0d want deadbeef/0/%0d", rd, e, lat, RW + 1);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd, erd; logic e, ee;
        int lat, nrd, nwe, nb, na, elat, enrd, enwe;
        model(1, 2'd2, 0, 32'h10, 32'h11223344, erd, ee, elat, enrd, enwe);
        run_req(1, 2'd2, 0, 32'h10, 32'h11223344, rd, e, lat, nrd, nwe, nb, na);
        model(1, 2'd0, 0, 32'h11, 32'hFFFFFF5A, erd, ee, elat, enrd, enwe);
        run_req(1, 2'd0, 0, 32'h11, 32'hFFFFFF5A, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (mem_w[4] !== 32'h115A3344) begin
            bad++; $display("FAIL byte_store_mem got %h want 115a3344", mem_w[4]);
        end
        total++;
        if (lat !== RW + 2 || nrd !== RW || nwe !== 1 || nb !== 0) begin
            bad++;
            $display("FAIL byte_store lat/rd/we/both got %0d/%0d/%0d/%0d want %0d/%0d/1/0",
                     lat, nrd, nwe, nb, RW + 2, RW);
        end
        model(1, 2'd0, 0, 32'h11, 32'h80, erd, ee, elat, enrd, enwe);
        run_req(1, 2'd0, 0, 32'h11, 32'h80, rd, e, lat, nrd, nwe, nb, na);
        run_req(0, 2'd0, 0, 32'h11, 0, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (rd !== 32'hFFFFFF80) begin
            bad++; $display("FAIL byte_load_signed got %h want ffffff80", rd);
        end
        run_req(0, 2'd0, 1, 32'h11, 0, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (rd !== 32'h00000080) begin
            bad++; $display("FAIL byte_load_unsigned got %h want 00000080", rd);
        end
        model(1, 2'd2, 0, 32'h10, 32'h11223344, erd, ee, elat, enrd, enwe);
        run_req(1, 2'd2, 0, 32'h10, 32'h11223344, rd, e, lat, nrd, nwe, nb, na);
        model(1, 2'd1, 0, 32'h12, 32'h0000ABCD, erd, ee, elat, enrd, enwe);
        run_req(1, 2'd1, 0, 32'h12, 32'h0000ABCD, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (mem_w[4] !== 32'h1122ABCD) begin
            bad++; $display("FAIL half_store_mem got %h want 1122abcd", mem_w[4]);
        end
        run_req(0, 2'd1, 0, 32'h12, 0, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (rd !== 32'hFFFFABCD || lat !== RW + 1) begin
            bad++; $display("FAIL half_load_signed got %h/%0d want ffffabcd/%0d", rd, lat, RW + 1);
        end
        run_req(0, 2'd1, 1, 32'h10, 0, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (rd !== 32'h00001122) begin
            bad++; $display("FAIL half_load_hi got %h want 00001122", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [0:5];
        logic [1:0]  sizes [0:5];
        logic [31:0] rd; logic e;
        int lat, nrd, nwe, nb, na;
        addrs = '{32'h13, 32'h11, 32'h10, 32'h3FE, 32'h3FD, 32'h400};
        sizes = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd0, 2'd2};
        for (int i = 0; i < 6; i++) begin
            run_req(i[0], sizes[i], 0, addrs[i], 32'h12345678, rd, e, lat, nrd, nwe, nb, na);
            total++;
            if (e !== 1'b1 || lat !== 1 || nrd !== 0 || nwe !== 0 || rd !== 32'h0) begin
                bad++;
                $display("FAIL err_case%0d err/lat/rd/we/rdata got %b/%0d/%0d/%0d/%h want 1/1/0/0/0",
                         i, e, lat, nrd, nwe, rd);
            end
        end
        run_req(0, 2'd2, 0, 32'h3FC, 0, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (e !== 1'b0 || rd !== ref_word(255)) begin
            bad++; $display("FAIL last_word err/rdata got %b/%h want 0/%h", e, rd, ref_word(255));
        end
    endtask

    task automatic test_reset_write();
        logic [31:0] rd, erd; logic e, ee;
        int lat, nrd, nwe, nb, na, elat, enrd, enwe, seen, nresp;
        model(1, 2'd2, 0, 32'h10, 32'h11223344, erd, ee, elat, enrd, enwe);
        run_req(1, 2'd2, 0, 32'h10, 32'h11223344, rd, e, lat, nrd, nwe, nb, na);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        req_write = 1; req_size = 2'd0; req_unsigned = 0;
        req_addr = 32'h11; req_wdata = 32'h77; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_writeenable) begin seen = 1; break; end
        end
        total++;
        if (seen !== 1) begin bad++; $display("FAIL rst_wr_reach got %0d want 1", seen); end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({req_ready, resp_valid, mem_read, mem_writeenable} !== 4'b1000 ||
            mem_address !== 32'h0 || mem_writedata !== 32'h0) begin
            bad++;
            $display("FAIL rst_wr_outputs got %b %h %h want 1000 0 0",
                     {req_ready, resp_valid, mem_read, mem_writeenable}, mem_address, mem_writedata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if (mem_w[4] !== ref_word(4)) begin
            bad++; $display("FAIL rst_wr_mem got %h want %h", mem_w[4], ref_word(4));
        end
        nresp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        total++;
        if (nresp !== 0) begin bad++; $display("FAIL rst_wr_noresp got %0d want 0", nresp); end
        run_req(0, 2'd2, 0, 32'h10, 0, rd, e, lat, nrd, nwe, nb, na);
        total++;
        if (rd !== 32'h11223344 || lat !== RW + 1) begin
            bad++; $display("FAIL rst_wr_after got %h/%0d want 11223344/%0d", rd, lat, RW + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] erd; logic ee;
        int elat, enrd, enwe, lat;
        model(1, 2'd2, 0, 32'h20, 32'hCAFEF00D, erd, ee, elat, enrd, enwe);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        req_write = 1; req_size = 2'd2; req_unsigned = 0;
        req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        @(posedge clk);
        #1 req_write = 0; req_wdata = 32'h0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            total++;
            if (req_ready !== (n == 3) || resp_valid !== (n == 2)) begin
                bad++;
                $display("FAIL b2b_cycle%0d ready/resp got %b/%b want %b/%b",
                         n, req_ready, resp_valid, n == 3, n == 2);
            end
        end
        model(0, 2'd2, 0, 32'h20, 0, erd, ee, elat, enrd, enwe);
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (resp_valid) begin lat = k; break; end
        end
        total++;
        if (lat !== elat || resp_rdata !== erd) begin
            bad++; $display("FAIL b2b_second lat/rdata got %0d/%h want %0d/%h", lat, resp_rdata, elat, erd);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, erd; logic w, u, e, ee; logic [1:0] sz;
        int lat, nrd, nwe, nb, na, elat, enrd, enwe;
        for (int t = 0; t < 120; t++) begin
            w  = 1'($urandom);
            u  = 1'($urandom);
            sz = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom % 10 == 0) ? $urandom : 32'($urandom_range(0, MB - 1));
            if ($urandom % 4 != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            model(w, sz, u, a, wd, erd, ee, elat, enrd, enwe);
            run_req(w, sz, u, a, wd, rd, e, lat, nrd, nwe, nb, na);
            total++;
            if (e !== ee || rd !== erd || lat !== elat) begin
                bad++;
                $display("FAIL rand%0d err/rdata/lat got %b/%h/%0d want %b/%h/%0d",
                         t, e, rd, lat, ee, erd, elat);
            end
            total++;
            if (nrd !== enrd || nwe !== enwe || nb !== 0 || na !== 0) begin
                bad++;
                $display("FAIL rand%0d rd/we/both/addr got %0d/%0d/%0d/%0d want %0d/%0d/0/0",
                         t, nrd, nwe, nb, na, enrd, enwe);
            end
            if (w && !ee) begin
                total++;
                if (mem_w[a[9:2]] !== ref_word(int'(a[9:2]))) begin
                    bad++;
                    $display("FAIL rand%0d mem got %h want %h", t, mem_w[a[9:2]], ref_word(int'(a[9:2])));
                end
            end
        end
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = init_val(i);
            for (int j = 0; j < 4; j++) refb[4*i+j] = v[31-8*j -: 8];
        end
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_reset_write();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
